// File: rtl/vec_pkg.sv
// Shared definitions for the vector lane sequencer: funct6 codes, operand select, FSM state.
package vec_pkg;

    localparam logic [5:0] F6_ADD  = 6'b000000;
    localparam logic [5:0] F6_SUB  = 6'b000010;
    localparam logic [5:0] F6_MINU = 6'b000100;
    localparam logic [5:0] F6_MIN  = 6'b000101;
    localparam logic [5:0] F6_MAXU = 6'b000110;
    localparam logic [5:0] F6_MAX  = 6'b000111;
    localparam logic [5:0] F6_AND  = 6'b001001;
    localparam logic [5:0] F6_OR   = 6'b001010;
    localparam logic [5:0] F6_XOR  = 6'b001011;

    localparam logic [2:0] OPT_VV = 3'b001;
    localparam logic [2:0] OPT_VX = 3'b010;
    localparam logic [2:0] OPT_VI = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } vseq_state_e;

    // Operation controls captured at start
    typedef struct packed {
        logic [5:0] funct6;
        logic       use_scalar;
        logic [1:0] vsew;
        logic       vm;
    } vop_ctrl_t;

    function automatic logic f6_supported(input logic [5:0] f6);
        case (f6)
            F6_ADD, F6_SUB, F6_MINU, F6_MIN, F6_MAXU, F6_MAX,
            F6_AND, F6_OR, F6_XOR: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] sew_mask(input logic [1:0] vsew);
        case (vsew)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// One combinational lane: r = b OP a on SEW-bit elements (b = vs2, a = vs1/scalar).
module vec_lane_alu
    import vec_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [1:0]  vsew,
    input  logic [5:0]  opcode,
    output logic [63:0] r
);

    logic [63:0] msk;
    logic [63:0] a_z;
    logic [63:0] b_z;
    logic [63:0] a_s;
    logic [63:0] b_s;
    logic [63:0] raw;
    logic        lt_u;
    logic        lt_s;

    function automatic logic [63:0] sext(input logic [63:0] x, input logic [1:0] s);
        case (s)
            2'd0:    return {{56{x[7]}},  x[7:0]};
            2'd1:    return {{48{x[15]}}, x[15:0]};
            2'd2:    return {{32{x[31]}}, x[31:0]};
            default: return x;
        endcase
    endfunction

    always_comb begin
        msk  = sew_mask(vsew);
        a_z  = a & msk;
        b_z  = b & msk;
        a_s  = sext(a, vsew);
        b_s  = sext(b, vsew);
        lt_u = b_z < a_z;
        lt_s = $signed(b_s) < $signed(a_s);
        case (opcode)
            F6_ADD:  raw = b + a;
            F6_SUB:  raw = b - a;
            F6_MINU: raw = lt_u ? b_z : a_z;
            F6_MIN:  raw = lt_s ? b_z : a_z;
            F6_MAXU: raw = lt_u ? a_z : b_z;
            F6_MAX:  raw = lt_s ? a_z : b_z;
            F6_AND:  raw = b & a;
            F6_OR:   raw = b | a;
            F6_XOR:  raw = b ^ a;
            default: raw = b;
        endcase
        r = raw & msk;
    end

endmodule

// File: rtl/vec_lane_sequencer.sv
// Sequences an RVV integer op over vl elements, L lanes per cycle, with mask/tail undisturbed.
module vec_lane_sequencer
    import vec_pkg::*;
#(
    parameter int unsigned VLEN     = 128,
    parameter int unsigned NB_LANES = 3,
    parameter int unsigned VL_W     = $clog2(VLEN/8) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [5:0]        opcode,
    input  logic [2:0]        op_type,
    input  logic [2:0]        vsew,
    input  logic [VL_W-1:0]   vl,
    input  logic [VLEN-1:0]   vs1,
    input  logic [VLEN-1:0]   vs2,
    input  logic [VLEN-1:0]   vd_old,
    input  logic [63:0]       scalar,
    input  logic              vm,
    input  logic [VLEN/8-1:0] vmask,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [VLEN-1:0]   vd
);

    localparam int unsigned L     = 1 << NB_LANES;
    localparam int unsigned NELEM = VLEN / 8;
    localparam int unsigned IDX_W = VL_W + 1;

    vseq_state_e      state_q, state_n;
    vop_ctrl_t        ctrl_q, ctrl_n;
    logic [VL_W-1:0]  vl_q, vl_n;
    logic [VLEN-1:0]  vs1_q, vs1_n;
    logic [VLEN-1:0]  vs2_q, vs2_n;
    logic [63:0]      scalar_q, scalar_n;
    logic [NELEM-1:0] vmask_q, vmask_n;
    logic [IDX_W-1:0] elem_idx_q, elem_idx_n;
    logic             busy_n, done_n, illegal_n;
    logic [VLEN-1:0]  vd_n;
    logic [VLEN-1:0]  wmask;
    logic             start_bad_c;

    logic [31:0]      lane_e   [L];
    logic [31:0]      lane_off [L];
    logic [NELEM-1:0] lane_msk [L];
    logic             lane_act [L];
    logic [63:0]      lane_a   [L];
    logic [63:0]      lane_b   [L];
    logic [63:0]      lane_r   [L];

    // Per-lane element index, bit offset, activity and operand slices
    always_comb begin
        for (int k = 0; k < L; k++) begin
            lane_e[k]   = 32'(elem_idx_q) + 32'(k);
            lane_off[k] = lane_e[k] << (32'(ctrl_q.vsew) + 32'd3);
            lane_msk[k] = vmask_q >> lane_e[k];
            lane_act[k] = (lane_e[k] < 32'(vl_q)) && (ctrl_q.vm || lane_msk[k][0]);
            lane_b[k]   = 64'(vs2_q >> lane_off[k]);
            lane_a[k]   = ctrl_q.use_scalar ? scalar_q : 64'(vs1_q >> lane_off[k]);
        end
    end

    for (genvar g = 0; g < L; g++) begin : g_lane
        vec_lane_alu u_alu (
            .a      (lane_a[g]),
            .b      (lane_b[g]),
            .vsew   (ctrl_q.vsew),
            .opcode (ctrl_q.funct6),
            .r      (lane_r[g])
        );
    end

    always_comb begin
        start_bad_c = (vsew > 3'd3)
                   || !f6_supported(opcode)
                   || ((op_type != OPT_VV) && (op_type != OPT_VX) && (op_type != OPT_VI))
                   || (32'(vl) > (VLEN >> (32'(vsew) + 32'd3)));
    end

    // Next-state and next-output logic
    always_comb begin
        state_n    = state_q;
        ctrl_n     = ctrl_q;
        vl_n       = vl_q;
        vs1_n      = vs1_q;
        vs2_n      = vs2_q;
        scalar_n   = scalar_q;
        vmask_n    = vmask_q;
        elem_idx_n = elem_idx_q;
        busy_n     = busy;
        done_n     = 1'b0;
        illegal_n  = 1'b0;
        vd_n       = vd;
        wmask      = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ctrl_n.funct6     = opcode;
                    ctrl_n.use_scalar = (op_type != OPT_VV);
                    ctrl_n.vsew       = vsew[1:0];
                    ctrl_n.vm         = vm;
                    vl_n              = vl;
                    vs1_n             = vs1;
                    vs2_n             = vs2;
                    scalar_n          = scalar;
                    vmask_n           = vmask;
                    elem_idx_n        = '0;
                    vd_n              = vd_old;
                    if (start_bad_c || (vl == '0)) begin
                        state_n   = ST_DONE;
                        done_n    = 1'b1;
                        illegal_n = start_bad_c;
                    end else begin
                        state_n = ST_RUN;
                        busy_n  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                for (int k = 0; k < L; k++) begin
                    if (lane_act[k]) begin
                        wmask = VLEN'(sew_mask(ctrl_q.vsew)) << lane_off[k];
                        vd_n  = (vd_n & ~wmask) | ((VLEN'(lane_r[k]) << lane_off[k]) & wmask);
                    end
                end
                elem_idx_n = elem_idx_q + IDX_W'(L);
                if ((32'(elem_idx_q) + L) >= 32'(vl_q)) begin
                    state_n = ST_DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            vl_q       <= '0;
            vs1_q      <= '0;
            vs2_q      <= '0;
            scalar_q   <= '0;
            vmask_q    <= '0;
            elem_idx_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            illegal    <= 1'b0;
            vd         <= '0;
        end else begin
            state_q    <= state_n;
            ctrl_q     <= ctrl_n;
            vl_q       <= vl_n;
            vs1_q      <= vs1_n;
            vs2_q      <= vs2_n;
            scalar_q   <= scalar_n;
            vmask_q    <= vmask_n;
            elem_idx_q <= elem_idx_n;
            busy       <= busy_n;
            done       <= done_n;
            illegal    <= illegal_n;
            vd         <= vd_n;
        end
    end

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Directed and random checks of vec_lane_sequencer against an element-level reference model.
module tb_vec_lane_sequencer;

    localparam int VLEN = 128;
    localparam int NL   = 8;

    logic         clk;
    logic         resetn;
    logic         start;
    logic [5:0]   opcode;
    logic [2:0]   op_type;
    logic [2:0]   vsew;
    logic [4:0]   vl;
    logic [127:0] vs1, vs2, vd_old;
    logic [63:0]  scalar;
    logic         vm;
    logic [15:0]  vmask;
    logic         busy, done, illegal;
    logic [127:0] vd;

    int total = 0;
    int bad   = 0;

    vec_lane_sequencer dut (
        .clk(clk), .resetn(resetn), .start(start), .opcode(opcode), .op_type(op_type),
        .vsew(vsew), .vl(vl), .vs1(vs1), .vs2(vs2), .vd_old(vd_old), .scalar(scalar),
        .vm(vm), .vmask(vmask), .busy(busy), .done(done), .illegal(illegal), .vd(vd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [5:0] f6, input logic [2:0] opt,
                                     input logic [2:0] sew, input int n);
        bit f6_ok;
        f6_ok = f6 inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd11};
        if (sew > 3) return 0;
        if (!f6_ok) return 0;
        if (!(opt inside {3'b001, 3'b010, 3'b100})) return 0;
        return n <= (VLEN / (8 << sew));
    endfunction

    function automatic logic [63:0] ref_op(input logic [5:0] f6, input logic [63:0] a,
                                           input logic [63:0] b, input int sew);
        logic [63:0] m, sg, ua, ub, r;
        longint sa, sb;
        m  = (sew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sew) - 64'd1);
        sg = 64'd1 << (sew - 1);
        ua = a & m;
        ub = b & m;
        sa = longint'(ua ^ sg) - longint'(sg);
        sb = longint'(ub ^ sg) - longint'(sg);
        case (f6)
            6'd0:    r = ub + ua;
            6'd2:    r = ub - ua;
            6'd4:    r = (ub < ua) ? ub : ua;
            6'd5:    r = (sb < sa) ? ub : ua;
            6'd6:    r = (ub > ua) ? ub : ua;
            6'd7:    r = (sb > sa) ? ub : ua;
            6'd9:    r = ub & ua;
            6'd10:   r = ub | ua;
            6'd11:   r = ub ^ ua;
            default: r = 64'd0;
        endcase
        return r & m;
    endfunction

    function automatic logic [127:0] ref_vd(input logic [5:0] f6, input logic [2:0] opt,
            input logic [2:0] sew_sel, input int n, input logic [127:0] a1,
            input logic [127:0] a2, input logic [127:0] old, input logic [63:0] sc,
            input logic m_en, input logic [15:0] mk);
        logic [127:0] res;
        logic [63:0]  ea, eb, r;
        int sew;
        res = old;
        if (!ref_legal(f6, opt, sew_sel, n)) return res;
        sew = 8 << sew_sel;
        for (int e = 0; e < VLEN / sew; e++) begin
            if (e < n && (m_en || mk[e])) begin
                eb = 64'(a2 >> (e * sew));
                ea = (opt == 3'b001) ? 64'(a1 >> (e * sew)) : sc;
                r  = ref_op(f6, ea, eb, sew);
                for (int i = 0; i < sew; i++) res[e * sew + i] = r[i];
            end
        end
        return res;
    endfunction

    // Issue one operation at a negedge and check latency, illegal flag, result and pulse width
    task automatic run_op(input string tag, input logic [5:0] f6, input logic [2:0] opt,
                          input logic [2:0] sew, input logic [4:0] n, input logic [127:0] a1,
                          input logic [127:0] a2, input logic [127:0] old, input logic [63:0] sc,
                          input logic m_en, input logic [15:0] mk, output int lat);
        bit           legal;
        int           exp_lat;
        logic [127:0] exp_vd;
        legal   = ref_legal(f6, opt, sew, int'(n));
        exp_lat = (legal && n != 0) ? ((int'(n) + NL - 1) / NL + 1) : 1;
        exp_vd  = ref_vd(f6, opt, sew, int'(n), a1, a2, old, sc, m_en, mk);
        opcode = f6; op_type = opt; vsew = sew; vl = n; vs1 = a1; vs2 = a2;
        vd_old = old; scalar = sc; vm = m_en; vmask = mk;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_busy"}, 128'(busy), 128'(exp_lat > 1));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 60);
        check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        check({tag, "_illegal"}, 128'(illegal), 128'(!legal));
        check({tag, "_vd"}, vd, exp_vd);
        @(negedge clk);
        check({tag, "_pulse"}, {126'd0, done, illegal}, 128'd0);
        check({tag, "_hold"}, vd, exp_vd);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [5:0]   sup [9];
        logic [5:0]   f6;
        logic [2:0]   opt, sew;
        logic [4:0]   n;
        logic [4:0]   imm;
        logic [63:0]  sc;
        logic [127:0] old, a1, a2;
        int           lat, maxn;
        bit           saw_done;

        sup = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd11};
        resetn = 1'b0; start = 1'b0; opcode = '0; op_type = 3'b001; vsew = '0; vl = '0;
        vs1 = '0; vs2 = '0; vd_old = '0; scalar = '0; vm = 1'b1; vmask = '0;

        // Power-up idle behaviour
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        vd_old = rnd128();
        repeat (4) @(negedge clk);
        check("rst_vd", vd, 128'd0);
        check("rst_busy_done", {126'd0, busy, done}, 128'd0);
        check("rst_illegal", 128'(illegal), 128'd0);

        // VV add, byte elements, full 16
        run_op("add8", 6'd0, 3'b001, 3'd0, 5'd16, {16{8'hFF}}, {16{8'h02}}, rnd128(),
               64'd0, 1'b1, 16'h0000, lat);
        check("add8_const", vd, {16{8'h01}});
        check("add8_lat3", 128'(lat), 128'd3);

        // VX sub at SEW=64 with one element
        old = rnd128();
        a2  = rnd128();
        a2[63:0] = 64'd0;
        run_op("sub64", 6'd2, 3'b010, 3'd3, 5'd1, rnd128(), a2, old, 64'd1, 1'b1, 16'h0, lat);
        check("sub64_const", vd, {old[127:64], 64'hFFFF_FFFF_FFFF_FFFF});

        // VI signed max, masked, SEW=32
        old = rnd128();
        run_op("max32", 6'd7, 3'b100, 3'd2, 5'd3, rnd128(), {4{32'hFFFF_FFFB}}, old,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 16'h0005, lat);
        check("max32_const", vd, {old[127:96], 32'hFFFF_FFFF, old[63:32], 32'hFFFF_FFFF});

        // Rejected starts and the vl=0 corner
        old = rnd128();
        run_op("bad_op", 6'h3F, 3'b001, 3'd0, 5'd4, rnd128(), rnd128(), old, 64'd0, 1'b1, 16'h0, lat);
        check("bad_op_keep", vd, old);
        old = rnd128();
        run_op("bad_vl", 6'd0, 3'b001, 3'd0, 5'd17, rnd128(), rnd128(), old, 64'd0, 1'b1, 16'h0, lat);
        check("bad_vl_keep", vd, old);
        run_op("bad_opt", 6'd0, 3'b011, 3'd1, 5'd2, rnd128(), rnd128(), rnd128(), 64'd0, 1'b1, 16'h0, lat);
        run_op("bad_sew", 6'd0, 3'b001, 3'd4, 5'd1, rnd128(), rnd128(), rnd128(), 64'd0, 1'b1, 16'h0, lat);
        run_op("vl0", 6'd11, 3'b001, 3'd0, 5'd0, rnd128(), rnd128(), rnd128(), 64'd0, 1'b1, 16'h0, lat);
        run_op("vl9", 6'd4, 3'b001, 3'd0, 5'd9, rnd128(), rnd128(), rnd128(), 64'd0, 1'b1, 16'h0, lat);

        // Random operations
        for (int t = 0; t < 40; t++) begin
            f6   = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(12, 63)) : sup[$urandom_range(0, 8)];
            opt  = ($urandom_range(0, 9) == 0) ? 3'b011 : 3'(1 << $urandom_range(0, 2));
            sew  = ($urandom_range(0, 11) == 0) ? 3'd5 : 3'($urandom_range(0, 3));
            maxn = (sew > 3) ? 16 : (16 >> sew);
            n    = ($urandom_range(0, 7) == 0) ? 5'(maxn + 1) : 5'($urandom_range(0, maxn));
            imm  = 5'($urandom());
            sc   = (opt == 3'b100) ? {{59{imm[4]}}, imm} : {$urandom(), $urandom()};
            run_op("rnd", f6, opt, sew, n, rnd128(), rnd128(), rnd128(), sc,
                   1'($urandom()), 16'($urandom()), lat);
        end

        // Reset in the middle of RUN aborts without done
        opcode = 6'd0; op_type = 3'b001; vsew = 3'd0; vl = 5'd16; vm = 1'b1;
        vs1 = rnd128(); vs2 = rnd128(); vd_old = rnd128();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("abort_busy", 128'(busy), 128'd1);
        @(negedge clk);
        resetn = 1'b0;
        #2;
        check("abort_rst_vd", vd, 128'd0);
        check("abort_rst_flags", {125'd0, busy, done, illegal}, 128'd0);
        @(negedge clk);
        resetn   = 1'b1;
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        check("abort_no_done", 128'(saw_done), 128'd0);
        run_op("after_rst", 6'd5, 3'b001, 3'd0, 5'd8, rnd128(), rnd128(), rnd128(), 64'd0,
               1'b0, 16'($urandom()), lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
